// File: rtl/clk_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_switch_pkg
// Description : Shared state encoding and clock-source select constants
//               used by the clock-switch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Presence of the clock named by a select value
    function automatic logic alive_of(input logic s, input logic a, input logic b);
        return (s == SEL_B) ? b : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_dly_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sw_dly_cnt
// Description : Loadable down counter shared by the settle and dwell phases;
//               saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_dly_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_switch_ctrl
// Description : Sequencer for the glitch-free clk_A/clk_B switch: drives sel,
//               waits out switch latency, enforces dwell and fails over on a
//               dead active clock.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int DWELL_CYC  = 32,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic alive_a,
    input  logic alive_b,
    output logic sel,
    output logic cur_sel,
    output logic busy,
    output logic done,
    output logic err,
    output logic failover
);

    localparam logic [CNT_W-1:0] c_SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_DWELL_LD  = CNT_W'(DWELL_CYC - 1);

    state_t r_state;
    logic   r_sel;
    logic   r_cur_sel;
    logic   r_busy;
    logic   r_done;
    logic   r_err;
    logic   r_failover;

    logic             w_idle;
    logic             w_fo_cond;
    logic             w_accept;
    logic             w_tgt_alive;
    logic             w_start;
    logic             w_zero;
    logic             w_ld;
    logic [CNT_W-1:0] w_ld_val;
    logic             w_dec;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_fo_cond   = w_idle & ~alive_of(r_cur_sel, alive_a, alive_b)
                                &  alive_of(~r_cur_sel, alive_a, alive_b);
    assign req_ready   = ~rst & w_idle & ~w_fo_cond;
    assign w_accept    = req_valid & req_ready;
    assign w_tgt_alive = alive_of(req_sel, alive_a, alive_b);
    assign w_start     = w_accept & w_tgt_alive & (req_sel != r_cur_sel);

    always_comb begin
        w_ld     = 1'b0;
        w_ld_val = c_SETTLE_LD;
        case (r_state)
            ST_IDLE:   w_ld = w_fo_cond | w_start;
            ST_SETTLE: begin
                w_ld     = w_zero;
                w_ld_val = c_DWELL_LD;
            end
            default:   w_ld = 1'b0;
        endcase
    end

    assign w_dec = (r_state == ST_SETTLE) | (r_state == ST_DWELL);

    sw_dly_cnt #(
        .CNT_W (CNT_W)
    ) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_ld),
        .load_val (w_ld_val),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= SEL_A;
            r_cur_sel  <= SEL_A;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_failover <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_failover <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A dead active clock takes priority over any pending request
                    if (w_fo_cond) begin
                        r_sel      <= ~r_cur_sel;
                        r_failover <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETTLE;
                    end else if (w_accept) begin
                        if (!w_tgt_alive) begin
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end else if (req_sel == r_cur_sel) begin
                            r_done  <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_sel   <= req_sel;
                            r_busy  <= 1'b1;
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_zero) begin
                        r_cur_sel <= r_sel;
                        r_done    <= 1'b1;
                        r_state   <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (w_zero) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sel      = r_sel;
    assign cur_sel  = r_cur_sel;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign failover = r_failover;

endmodule
`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_switch_ctrl
// Description : Self-checking bench for clk_switch_ctrl with a scoreboard of
//               expected done/err pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_switch_ctrl;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic req_valid = 1'b0;
    logic req_sel   = 1'b0;
    logic alive_a   = 1'b1;
    logic alive_b   = 1'b1;
    logic req_ready;
    logic sel;
    logic cur_sel;
    logic busy;
    logic done;
    logic err;
    logic failover;

    clk_switch_ctrl #(
        .SETTLE_CYC (16),
        .DWELL_CYC  (32),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .alive_a   (alive_a),
        .alive_b   (alive_b),
        .sel       (sel),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .failover  (failover)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        bit   is_err;
        int   at;
        logic cur;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input bit is_err, input int at, input logic cur);
        exp_t e;
        e.is_err = is_err;
        e.at     = at;
        e.cur    = cur;
        sb_q.push_back(e);
    endtask

    // Every done/err pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_kind_err",  32'(err),  32'(e.is_err));
                check("sb_kind_done", 32'(done), 32'(!e.is_err));
                check("sb_cycle",     cyc,       e.at);
                check("sb_cur_sel",   32'(cur_sel), 32'(e.cur));
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int a;
        int k;

        repeat (3) @(negedge clk);
        check("rst_sel",      32'(sel),       32'd0);
        check("rst_cur_sel",  32'(cur_sel),   32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_ready",    32'(req_ready), 32'd0);
        check("rst_pulses",   {29'd0, done, err, failover}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_sel",   32'(sel),       32'd0);
        check("post_rst_pulse", {29'd0, done, err, failover}, 32'd0);

        // Full switch A -> B
        t = cyc; req_valid = 1'b1; req_sel = 1'b1;
        push_exp(1'b0, t + 17, 1'b1);
        @(negedge clk); req_valid = 1'b0;
        check("sw_b_sel",      32'(sel),       32'd1);
        check("sw_b_busy",     32'(busy),      32'd1);
        check("sw_b_ready",    32'(req_ready), 32'd0);
        check("sw_b_cur_old",  32'(cur_sel),   32'd0);
        wait_to(t + 16);
        check("sw_b_settle_cur", 32'(cur_sel), 32'd0);
        wait_to(t + 48);
        check("sw_b_dwell_busy",  32'(busy),      32'd1);
        check("sw_b_dwell_ready", 32'(req_ready), 32'd0);
        wait_to(t + 50);
        check("sw_b_end_busy",  32'(busy),      32'd0);
        check("sw_b_end_ready", 32'(req_ready), 32'd1);
        check("sw_b_end_cur",   32'(cur_sel),   32'd1);

        // No-op request for the already active source
        t = cyc; req_valid = 1'b1; req_sel = 1'b1;
        push_exp(1'b0, t + 1, 1'b1);
        @(negedge clk); req_valid = 1'b0;
        check("noop_ready", 32'(req_ready), 32'd0);
        check("noop_sel",   32'(sel),       32'd1);
        check("noop_busy",  32'(busy),      32'd0);
        wait_to(t + 2);
        check("noop_ready_back", 32'(req_ready), 32'd1);

        // Switch back B -> A
        t = cyc; req_valid = 1'b1; req_sel = 1'b0;
        push_exp(1'b0, t + 17, 1'b0);
        @(negedge clk); req_valid = 1'b0;
        check("sw_a_sel", 32'(sel), 32'd0);
        wait_to(t + 50);
        check("sw_a_cur",   32'(cur_sel),   32'd0);
        check("sw_a_ready", 32'(req_ready), 32'd1);

        // Request to a dead target clock
        alive_b = 1'b0;
        t = cyc; req_valid = 1'b1; req_sel = 1'b1;
        push_exp(1'b1, t + 1, 1'b0);
        @(negedge clk); req_valid = 1'b0;
        check("err_sel",      32'(sel),      32'd0);
        check("err_busy",     32'(busy),     32'd0);
        check("err_failover", 32'(failover), 32'd0);
        wait_to(t + 2);
        check("err_ready_back", 32'(req_ready), 32'd1);
        alive_b = 1'b1;

        // Reset in the middle of SETTLE aborts without a done pulse
        t = cyc; req_valid = 1'b1; req_sel = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        wait_to(t + 5);
        check("abort_pre_sel",  32'(sel),  32'd1);
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sel",   32'(sel),     32'd0);
        check("abort_busy",  32'(busy),    32'd0);
        check("abort_cur",   32'(cur_sel), 32'd0);
        check("abort_done",  32'(done),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Active clock dies with a request pending: failover wins
        t = cyc; alive_a = 1'b0; req_valid = 1'b1; req_sel = 1'b1;
        #1;
        check("fo_ready_blocked", 32'(req_ready), 32'd0);
        push_exp(1'b0, t + 17, 1'b1);
        @(negedge clk);
        check("fo_pulse", 32'(failover), 32'd1);
        check("fo_sel",   32'(sel),      32'd1);
        check("fo_busy",  32'(busy),     32'd1);
        @(negedge clk);
        check("fo_pulse_once", 32'(failover), 32'd0);
        wait_to(t + 48);
        check("fo_dwell_ready", 32'(req_ready), 32'd0);
        k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        a = cyc;
        check("fo_held_ready", 32'(req_ready), 32'd1);
        check("fo_accept_late", 32'(a >= t + 49), 32'd1);
        push_exp(1'b0, a + 1, 1'b1);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        alive_a = 1'b1;

        // Both clocks dead: no failover, requests rejected
        alive_a = 1'b0; alive_b = 1'b0;
        t = cyc; req_valid = 1'b1; req_sel = 1'b0;
        push_exp(1'b1, t + 1, 1'b1);
        @(negedge clk); req_valid = 1'b0;
        check("dead_failover", 32'(failover), 32'd0);
        check("dead_sel",      32'(sel),      32'd1);
        check("dead_busy",     32'(busy),     32'd0);
        repeat (2) @(negedge clk);
        check("dead_no_fo", {30'd0, failover, busy}, 32'd0);
        alive_a = 1'b1; alive_b = 1'b1;

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
